// File: rtl/onchip_mem_reader_pkg.sv
// Shared widths and FSM state encoding for the on-chip memory burst reader.
package onchip_mem_reader_pkg;

    localparam int unsigned DEF_ADDR_W     = 14;
    localparam int unsigned DEF_DATA_W     = 32;
    localparam int unsigned DEF_FIFO_DEPTH = 4;
    localparam int unsigned BE_W           = 4;
    localparam int unsigned ST_W           = 2;

    typedef logic [ST_W-1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_FETCH = 2'd1;
    localparam state_t ST_DRAIN = 2'd2;

endpackage

// File: rtl/onchip_mem_reader_fifo.sv
// Synchronous FIFO with occupancy count, registered valid flag and synchronous flush.
module onchip_mem_reader_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   i_flush,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_data,
    input  logic                   i_pop,
    output logic [WIDTH-1:0]       o_data,
    output logic                   o_valid,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_next;
    logic             r_valid;
    logic             w_wr;
    logic             w_rd;

    assign w_rd = i_pop & r_valid;
    assign w_wr = i_push & ((r_count != CNT_W'(DEPTH)) | w_rd);

    always_comb begin
        w_count_next = r_count;
        if (i_flush) begin
            w_count_next = '0;
        end else begin
            w_count_next = r_count + CNT_W'(w_wr) - CNT_W'(w_rd);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_valid  <= 1'b0;
        end else begin
            r_count <= w_count_next;
            r_valid <= (w_count_next != '0);
            if (i_flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_wr) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                if (w_rd) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
        end
    end

    // Data storage needs no reset; occupancy alone defines what is visible.
    always_ff @(posedge clk) begin
        if (w_wr && !i_flush) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_valid = r_valid;
    assign o_count = r_count;

endmodule

// File: rtl/onchip_mem_reader.sv
// Burst reader: streams `length` words from on-chip memory (1-cycle read latency)
// into a credit-limited buffer and out over a valid/ready port.
module onchip_mem_reader
    import onchip_mem_reader_pkg::*;
#(
    parameter int unsigned ADDR_W     = DEF_ADDR_W,
    parameter int unsigned DATA_W     = DEF_DATA_W,
    parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   length,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [BE_W-1:0]   mem_byteenable,
    output logic              mem_clken,
    input  logic [DATA_W-1:0] mem_readdata,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready
);

    localparam int unsigned LEN_W = ADDR_W + 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned SUM_W = CNT_W + 1;

    state_t            r_state;
    state_t            w_state_next;
    logic              r_busy;
    logic              w_busy_next;
    logic              r_done;
    logic              w_done_next;
    logic              r_cs;
    logic              w_cs_next;
    logic              r_inflight;
    logic              w_inflight_next;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] w_addr_next;
    logic [LEN_W-1:0]  r_left;
    logic [LEN_W-1:0]  w_left_next;
    logic              w_flush;
    logic              w_push;
    logic              w_pop;
    logic              w_credit_ok;
    logic              w_drain_empty;
    logic [CNT_W-1:0]  w_fifo_count;
    logic [SUM_W-1:0]  w_occ_next;

    assign w_pop  = out_valid & out_ready;
    assign w_push = r_inflight & ~w_flush;

    // Buffer occupancy plus outstanding read as it will stand next cycle, so chipselect can be registered.
    assign w_occ_next    = SUM_W'(w_fifo_count) + SUM_W'(r_inflight) + SUM_W'(r_cs) - SUM_W'(w_pop);
    assign w_credit_ok   = (w_occ_next < SUM_W'(FIFO_DEPTH));
    assign w_drain_empty = !r_inflight &&
                           ((w_fifo_count == CNT_W'(0)) || ((w_fifo_count == CNT_W'(1)) && w_pop));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_cs       <= 1'b0;
            r_inflight <= 1'b0;
            r_addr     <= '0;
            r_left     <= '0;
        end else begin
            r_state    <= w_state_next;
            r_busy     <= w_busy_next;
            r_done     <= w_done_next;
            r_cs       <= w_cs_next;
            r_inflight <= w_inflight_next;
            r_addr     <= w_addr_next;
            r_left     <= w_left_next;
        end
    end

    // r_left counts reads still to issue after the one currently on the bus.
    always_comb begin
        w_state_next    = r_state;
        w_busy_next     = r_busy;
        w_done_next     = 1'b0;
        w_cs_next       = 1'b0;
        w_inflight_next = r_cs;
        w_addr_next     = r_cs ? r_addr + ADDR_W'(1) : r_addr;
        w_left_next     = r_left;
        w_flush         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    if (length == '0) begin
                        w_done_next = 1'b1;
                    end else begin
                        w_state_next = ST_FETCH;
                        w_busy_next  = 1'b1;
                        w_cs_next    = 1'b1;
                        w_addr_next  = base_addr;
                        w_left_next  = length - LEN_W'(1);
                    end
                end
            end
            ST_FETCH: begin
                if (abort) begin
                    w_state_next    = ST_IDLE;
                    w_busy_next     = 1'b0;
                    w_inflight_next = 1'b0;
                    w_flush         = 1'b1;
                end else if (r_left == '0) begin
                    w_state_next = ST_DRAIN;
                end else if (w_credit_ok) begin
                    w_cs_next   = 1'b1;
                    w_left_next = r_left - LEN_W'(1);
                end
            end
            ST_DRAIN: begin
                if (abort) begin
                    w_state_next    = ST_IDLE;
                    w_busy_next     = 1'b0;
                    w_inflight_next = 1'b0;
                    w_flush         = 1'b1;
                end else if (w_drain_empty) begin
                    w_state_next = ST_IDLE;
                    w_busy_next  = 1'b0;
                    w_done_next  = 1'b1;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    onchip_mem_reader_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .i_flush (w_flush),
        .i_push  (w_push),
        .i_data  (mem_readdata),
        .i_pop   (w_pop),
        .o_data  (out_data),
        .o_valid (out_valid),
        .o_count (w_fifo_count)
    );

    assign busy           = r_busy;
    assign done           = r_done;
    assign mem_address    = r_addr;
    assign mem_chipselect = r_cs;
    assign mem_write      = 1'b0;
    assign mem_byteenable = 4'hF;
    assign mem_clken      = 1'b1;

endmodule

// File: tb/tb_onchip_mem_reader.sv
// Scoreboard bench for onchip_mem_reader: stimulus queues expected reads/words,
// a negedge monitor checks them together with a busy/done/credit reference model.
module tb_onchip_mem_reader;

    localparam int unsigned AW    = 14;
    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   length = '0;
    logic          busy;
    logic          done;
    logic [AW-1:0] mem_address;
    logic          mem_chipselect;
    logic          mem_write;
    logic [3:0]    mem_byteenable;
    logic          mem_clken;
    logic [DW-1:0] mem_readdata = '0;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready = 1'b1;

    logic [DW-1:0] mem [1 << AW];

    int n_checks = 0;
    int n_errors = 0;

    logic [DW-1:0] exp_q[$];
    logic [AW-1:0] addr_q[$];

    bit mb = 1'b0;
    bit exp_done = 1'b0;
    int words_left = 0;
    int issued = 0;
    int popped = 0;

    onchip_mem_reader #(
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .abort          (abort),
        .base_addr      (base_addr),
        .length         (length),
        .busy           (busy),
        .done           (done),
        .mem_address    (mem_address),
        .mem_chipselect (mem_chipselect),
        .mem_write      (mem_write),
        .mem_byteenable (mem_byteenable),
        .mem_clken      (mem_clken),
        .mem_readdata   (mem_readdata),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready)
    );

    always #5 clk = ~clk;

    // Memory slave: read data appears the cycle after chipselect.
    always @(posedge clk) begin
        if (mem_chipselect) mem_readdata <= mem[mem_address];
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    // Monitor and reference model, sampled mid-cycle.
    always @(negedge clk) begin
        bit hs;
        bit nb;
        bit nd;
        bit last;
        int occ;
        logic [DW-1:0] e;
        logic [AW-1:0] ea;
        if (!reset_n) begin
            mb = 1'b0;
            exp_done = 1'b0;
            words_left = 0;
            issued = 0;
            popped = 0;
            exp_q.delete();
            addr_q.delete();
        end else begin
            chk("busy", 32'(busy), 32'(mb));
            if (done || exp_done) chk("done", 32'(done), 32'(exp_done));
            hs   = out_valid && out_ready;
            occ  = issued - popped;
            nb   = mb;
            nd   = 1'b0;
            last = 1'b0;
            if (hs) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL out_extra: got word 0x%0h, required no word (t=%0t)", out_data, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_data", out_data, e);
                end
                popped++;
                if (mb && words_left > 0) begin
                    words_left--;
                    last = (words_left == 0);
                end
            end
            if (mem_chipselect) begin
                n_checks++;
                if (occ >= int'(DEPTH)) begin
                    n_errors++;
                    $display("FAIL credit: got %0d words outstanding with chipselect, required < %0d (t=%0t)",
                             occ, DEPTH, $time);
                end
                if (addr_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL rd_extra: got read of 0x%0h, required no read (t=%0t)", mem_address, $time);
                end else begin
                    ea = addr_q.pop_front();
                    chk("rd_addr", 32'(mem_address), 32'(ea));
                end
                issued++;
            end
            if (!mb) begin
                if (start) begin
                    if (length == '0) nd = 1'b1;
                    else begin
                        nb = 1'b1;
                        words_left = int'(length);
                    end
                end
            end else if (abort) begin
                nb = 1'b0;
                words_left = 0;
                issued = 0;
                popped = 0;
                exp_q.delete();
                addr_q.delete();
            end else if (last) begin
                nb = 1'b0;
                nd = 1'b1;
                issued = 0;
                popped = 0;
            end
            mb = nb;
            exp_done = nd;
        end
    end

    task automatic start_burst(input logic [AW-1:0] b, input logic [AW:0] l, input bit accept);
        @(posedge clk);
        #1;
        start     = 1'b1;
        base_addr = b;
        length    = l;
        if (accept) begin
            for (int k = 0; k < int'(l); k++) begin
                addr_q.push_back(AW'(int'(b) + k));
                exp_q.push_back(mem[AW'(int'(b) + k)]);
            end
        end
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input bit rnd);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(posedge clk);
            #1;
            if (rnd) out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        n_checks++;
        if (!seen) begin
            n_errors++;
            $display("FAIL done_timeout: got no done within %0d cycles, required done", budget);
        end
        out_ready = 1'b1;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int hs_cnt;
        #200000;
        $display("FAIL watchdog: got no finish by %0t, required finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int hs_cnt;
        for (int i = 0; i < (1 << AW); i++) mem[i] = DW'(i * 3);

        // Reset values while reset_n is low.
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_cs", 32'(mem_chipselect), 32'd0);
        chk("rst_addr", 32'(mem_address), 32'd0);
        chk("tie_write", 32'(mem_write), 32'd0);
        chk("tie_be", 32'(mem_byteenable), 32'hF);
        chk("tie_clken", 32'(mem_clken), 32'd1);
        @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (2) @(posedge clk);

        // Basic burst with exact latency.
        start_burst(14'h0010, 15'd4, 1'b1);
        @(negedge clk);
        chk("basic_cs_t1", 32'(mem_chipselect), 32'd1);
        chk("basic_addr_t1", 32'(mem_address), 32'h10);
        chk("basic_busy_t1", 32'(busy), 32'd1);
        @(negedge clk);
        chk("basic_valid_t2", 32'(out_valid), 32'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("basic_valid", 32'(out_valid), 32'd1);
            chk("basic_data", out_data, 32'h30 + 32'(3 * k));
        end
        @(negedge clk);
        chk("basic_done", 32'(done), 32'd1);
        chk("basic_busy_done", 32'(busy), 32'd0);
        @(negedge clk);
        chk("basic_done_once", 32'(done), 32'd0);

        // Address wrap-around.
        start_burst(14'h3FFE, 15'd4, 1'b1);
        wait_done(50, 1'b0);

        // Zero-length request.
        start_burst(14'h0123, 15'd0, 1'b0);
        @(negedge clk);
        chk("zero_done", 32'(done), 32'd1);
        chk("zero_busy", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);

        for (int i = 0; i < (1 << AW); i++) mem[i] = $urandom;

        // Backpressure with random ready.
        start_burst(14'($urandom), 15'd16, 1'b1);
        wait_done(400, 1'b1);

        // Start while busy is ignored.
        start_burst(14'h0100, 15'd8, 1'b1);
        @(posedge clk);
        #1;
        start = 1'b1;
        base_addr = 14'h2000;
        length = 15'd3;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(100, 1'b0);

        // Abort in IDLE is ignored.
        @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        chk("idle_abort_busy", 32'(busy), 32'd0);

        // Abort after three outputs, then a clean burst.
        start_burst(14'h0400, 15'd10, 1'b1);
        hs_cnt = 0;
        for (int i = 0; i < 100 && hs_cnt < 3; i++) begin
            @(negedge clk);
            if (out_valid && out_ready) hs_cnt++;
        end
        chk("abort_outputs", 32'(hs_cnt), 32'd3);
        @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_valid", 32'(out_valid), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        repeat (3) @(negedge clk);
        start_burst(14'h0800, 15'd5, 1'b1);
        wait_done(100, 1'b0);

        // Reset mid-burst.
        start_burst(14'h0200, 15'd12, 1'b1);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_cs", 32'(mem_chipselect), 32'd0);
        chk("mid_rst_addr", 32'(mem_address), 32'd0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("stale_valid", 32'(out_valid), 32'd0);
        end

        // Random bursts.
        for (int n = 0; n < 6; n++) begin
            start_burst(14'($urandom), 15'($urandom_range(1, 20)), 1'b1);
            wait_done(500, 1'b1);
            repeat (2) @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
